flag_branch_unit: RTL and testbench

- Consumer end of the ALU interface: captures the ALU's zero/ovfl/sign outputs into the architectural flag register (Z, V, N).
- Resolves conditional branches against those flags and produces a registered redirect (taken, target, flush) to the fetch stage.
- Sits between EX (ALU outputs) and the PC-select logic.
- Contains a forwarding path so a branch issued in the same cycle as a flag-setting instruction sees the new flags.

---
 rtl/flag_branch_unit_pkg.sv | 57 +++++
 rtl/flag_branch_unit_if.sv | 42 ++++
 rtl/branch_cond_eval.sv | 31 +++
 rtl/flag_branch_unit.sv | 98 +++++++++
 tb/tb_flag_branch_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/flag_branch_unit_pkg.sv
// Shared types for the flag/branch unit: ALU opcodes, condition codes,
// FSM states, flag bit positions and the flag-update rule.
package fbu_pkg;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_RED    = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRA    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] OP_PADDSB = 3'b111;

  localparam int FZ = 2;
  localparam int FV = 1;
  localparam int FN = 0;

  typedef enum logic [2:0] {
    C_NE  = 3'b000,
    C_EQ  = 3'b001,
    C_GT  = 3'b010,
    C_LT  = 3'b011,
    C_GTE = 3'b100,
    C_LTE = 3'b101,
    C_OV  = 3'b110,
    C_AL  = 3'b111
  } cond_e;

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } state_e;

  // Arithmetic ops write all flags, logic/shift ops write only Z,
  // RED/PADDSB leave the flags untouched.
  function automatic logic [2:0] upd_flags(
    input logic [2:0] f,
    input logic [2:0] op,
    input logic       z,
    input logic       v,
    input logic       n
  );
    logic [2:0] r;
    r = f;
    case (op)
      OP_ADD, OP_SUB: begin
        r[FZ] = z;
        r[FV] = v;
        r[FN] = n;
      end
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: r[FZ] = z;
      default: r = f;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// EX-to-branch-unit bundle: stall, ALU flag outputs, branch request
// and the registered redirect back to fetch.
interface flag_branch_unit_if #(
  parameter int PC_W  = 16,
  parameter int IMM_W = 9
);
  logic             stall;
  logic             alu_valid;
  logic [2:0]       alu_op;
  logic             alu_zero;
  logic             alu_ovfl;
  logic             alu_sign;
  logic             br_valid;
  logic             br_kind;
  logic [2:0]       br_cond;
  logic [PC_W-1:0]  br_pc;
  logic [IMM_W-1:0] br_imm;
  logic [PC_W-1:0]  br_reg;
  logic [2:0]       flags;
  logic             br_resolve;
  logic             br_taken;
  logic [PC_W-1:0]  br_target;
  logic             flush;

  modport master (
    output stall, alu_valid, alu_op,
    output alu_zero, alu_ovfl, alu_sign,
    output br_valid, br_kind, br_cond,
    output br_pc, br_imm, br_reg,
    input  flags, br_resolve, br_taken,
    input  br_target, flush
  );

  modport slave (
    input  stall, alu_valid, alu_op,
    input  alu_zero, alu_ovfl, alu_sign,
    input  br_valid, br_kind, br_cond,
    input  br_pc, br_imm, br_reg,
    output flags, br_resolve, br_taken,
    output br_target, flush
  );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational condition check: {Z,V,N} + cond code -> taken.
// Ports: i_flags, i_cond in; o_taken out.
module branch_cond_eval
  import fbu_pkg::*;
(
  input  logic [2:0] i_flags,
  input  logic [2:0] i_cond,
  output logic       o_taken
);
  logic w_z;
  logic w_v;
  logic w_n;

  assign w_z = i_flags[FZ];
  assign w_v = i_flags[FV];
  assign w_n = i_flags[FN];

  always_comb begin
    o_taken = 1'b0;
    unique case (cond_e'(i_cond))
      C_NE:  o_taken = !w_z;
      C_EQ:  o_taken = w_z;
      C_GT:  o_taken = !w_z && !w_n;
      C_LT:  o_taken = w_n;
      C_GTE: o_taken = w_z || !w_n;
      C_LTE: o_taken = w_n || w_z;
      C_OV:  o_taken = w_v;
      C_AL:  o_taken = 1'b1;
    endcase
  end
endmodule

// File: rtl/flag_branch_unit.sv
// Flag register + branch resolver with same-cycle flag forwarding.
// Ports: clk, rst_n, bus (slave side of flag_branch_unit_if).
module flag_branch_unit
  import fbu_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int IMM_W = 9
) (
  input logic               clk,
  input logic               rst_n,
  flag_branch_unit_if.slave bus
);
  state_e           r_state;
  state_e           w_state_nxt;
  logic [2:0]       r_flags;
  logic             r_resolve;
  logic             r_taken;
  logic             r_flush;
  logic [PC_W-1:0]  r_target;

  logic             w_adv;
  logic [2:0]       w_fwd;
  logic             w_cond;
  logic             w_accept;
  logic             w_take;
  logic [IMM_W-1:0] w_imm;
  logic [PC_W-1:0]  w_seq;
  logic [PC_W-1:0]  w_off;
  logic [PC_W-1:0]  w_tgt;

  assign w_adv = !bus.stall;

  // The ALU op in EX is older than the branch, so the branch
  // sees the flags as they will be after this edge.
  assign w_fwd = (bus.alu_valid && w_adv)
               ? upd_flags(r_flags, bus.alu_op,
                           bus.alu_zero, bus.alu_ovfl,
                           bus.alu_sign)
               : r_flags;

  branch_cond_eval u_cond (
    .i_flags (w_fwd),
    .i_cond  (bus.br_cond),
    .o_taken (w_cond)
  );

  assign w_imm = bus.br_imm;
  assign w_seq = bus.br_pc + PC_W'(2);
  assign w_off = PC_W'($signed(w_imm)) << 1;
  assign w_tgt = bus.br_kind ? bus.br_reg
                             : w_seq + w_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_adv) begin
      unique case (r_state)
        RUN:    if (bus.br_valid && w_cond)
                  w_state_nxt = SHADOW;
        SHADOW: w_state_nxt = RUN;
      endcase
    end
  end

  // The instruction after a taken branch is wrong-path.
  always_comb begin
    w_accept = w_adv && bus.br_valid && (r_state == RUN);
    w_take   = w_accept && w_cond;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags   <= 3'b000;
      r_resolve <= 1'b0;
      r_taken   <= 1'b0;
      r_flush   <= 1'b0;
      r_target  <= '0;
    end else begin
      r_resolve <= w_accept;
      r_taken   <= w_take;
      r_flush   <= w_take;
      if (w_adv)
        r_flags <= w_fwd;
      if (w_accept)
        r_target <= w_take ? w_tgt : w_seq;
    end
  end

  assign bus.flags      = r_flags;
  assign bus.br_resolve = r_resolve;
  assign bus.br_taken   = r_taken;
  assign bus.flush      = r_flush;
  assign bus.br_target  = r_target;
endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed + random bench for flag_branch_unit against a
// behavioural model of the flags, condition table and redirect.
module tb_flag_branch_unit;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  flag_branch_unit_if #(.PC_W(16), .IMM_W(9)) bus ();

  flag_branch_unit #(.PC_W(16), .IMM_W(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  // model state
  bit          mz, mv, mn;
  bit          msh;
  bit          e_res, e_tk, e_fl;
  logic [15:0] e_tgt;

  function automatic bit cond_ok(int c, bit z, bit v, bit n);
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || !n;
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("flags", 32'(bus.flags), 32'({mz, mv, mn}));
    chk("resolve", 32'(bus.br_resolve), 32'(e_res));
    chk("taken", 32'(bus.br_taken), 32'(e_tk));
    chk("flush", 32'(bus.flush), 32'(e_fl));
    chk("target", 32'(bus.br_target), 32'(e_tgt));
  endtask

  task automatic drive(input bit st, input bit av,
                       input logic [2:0] op,
                       input logic [2:0] zos,
                       input bit bv, input bit bk,
                       input logic [2:0] cc,
                       input logic [15:0] pc,
                       input logic [8:0] imm,
                       input logic [15:0] rg);
    bus.stall     = st;
    bus.alu_valid = av;
    bus.alu_op    = op;
    bus.alu_zero  = zos[2];
    bus.alu_ovfl  = zos[1];
    bus.alu_sign  = zos[0];
    bus.br_valid  = bv;
    bus.br_kind   = bk;
    bus.br_cond   = cc;
    bus.br_pc     = pc;
    bus.br_imm    = imm;
    bus.br_reg    = rg;
  endtask

  task automatic step(input bit st, input bit av,
                      input logic [2:0] op,
                      input logic [2:0] zos,
                      input bit bv, input bit bk,
                      input logic [2:0] cc,
                      input logic [15:0] pc,
                      input logic [8:0] imm,
                      input logic [15:0] rg);
    bit z, v, n, tk;
    int off, seq, t;
    drive(st, av, op, zos, bv, bk, cc, pc, imm, rg);
    e_res = 0;
    e_tk  = 0;
    e_fl  = 0;
    if (!st) begin
      z = mz; v = mv; n = mn;
      if (av) begin
        if (op == 0 || op == 1) begin
          z = zos[2]; v = zos[1]; n = zos[0];
        end else if (op == 2 || op == 4 || op == 5 || op == 6) begin
          z = zos[2];
        end
      end
      if (bv && !msh) begin
        tk  = cond_ok(int'(cc), z, v, n);
        off = imm[8] ? int'(imm) - 512 : int'(imm);
        seq = (int'(pc) + 2) & 'hFFFF;
        if (!tk)     t = seq;
        else if (bk) t = int'(rg);
        else         t = (seq + 2 * off) & 'hFFFF;
        e_tgt = t[15:0];
        e_res = 1;
        e_tk  = tk;
        e_fl  = tk;
        msh   = tk;
      end else begin
        msh = 0;
      end
      mz = z; mv = v; mn = n;
    end
    @(posedge clk);
    #1;
    chk_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    mz = 0; mv = 0; mn = 0; msh = 0;
    e_res = 0; e_tk = 0; e_fl = 0; e_tgt = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 1, 0, 7, 16'h10, 9'h1, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    #2 rst_n = 1'b1;
    idle();

    // ADD -> 010, then B OV taken
    step(0, 1, 3'b000, 3'b010, 0, 0, 0, 0, 0, 0);
    chk("plan_add_flags", 32'(bus.flags), 32'h2);
    step(0, 0, 0, 0, 1, 0, 3'b110, 16'h0040, 9'h004, 0);
    chk("plan_b_ov_tgt", 32'(bus.br_target), 32'h004A);
    chk("plan_b_ov_flush", 32'(bus.flush), 32'h1);
    idle();

    // XOR writes Z only, RED writes nothing
    step(0, 1, 3'b010, 3'b100, 0, 0, 0, 0, 0, 0);
    chk("plan_xor_flags", 32'(bus.flags), 32'h6);
    step(0, 1, 3'b011, 3'b011, 0, 0, 0, 0, 0, 0);
    chk("plan_red_flags", 32'(bus.flags), 32'h6);

    // same-cycle SUB + B LT uses forwarded N
    step(0, 1, 3'b001, 3'b001, 1, 0, 3'b011, 16'h0100, 9'h1FC, 0);
    chk("plan_fwd_tgt", 32'(bus.br_target), 32'h00FA);
    chk("plan_fwd_flags", 32'(bus.flags), 32'h1);
    idle();

    // BR taken, shadow branch ignored, next one resolves
    step(0, 0, 0, 0, 1, 1, 3'b111, 16'h0500, 0, 16'h1234);
    chk("plan_br_tgt", 32'(bus.br_target), 32'h1234);
    step(0, 0, 0, 0, 1, 0, 3'b111, 16'h0600, 9'h10, 0);
    chk("plan_shadow_nores", 32'(bus.br_resolve), 32'h0);
    step(0, 0, 0, 0, 1, 0, 3'b001, 16'h0200, 9'h10, 0);
    chk("plan_after_shadow", 32'(bus.br_resolve), 32'h1);

    // wrap-around target
    step(0, 0, 0, 0, 1, 0, 3'b111, 16'hFFFC, 9'h0FF, 0);
    chk("plan_wrap_tgt", 32'(bus.br_target), 32'h01FC);
    // stall arrives while the wrap pulse is up
    step(1, 1, 3'b000, 3'b111, 1, 0, 3'b111, 16'h0300, 9'h10, 0);
    idle();

    // branch held under 3-cycle stall
    repeat (3)
      step(1, 0, 0, 0, 1, 0, 3'b111, 16'h0300, 9'h10, 0);
    step(0, 0, 0, 0, 1, 0, 3'b111, 16'h0300, 9'h10, 0);
    chk("plan_stall_tgt", 32'(bus.br_target), 32'h0322);
    idle();
    idle();
    chk("plan_stall_single", 32'(bus.br_resolve), 32'h0);

    // reset mid-cycle with a branch pending
    step(0, 1, 3'b000, 3'b111, 1, 0, 3'b000, 16'h0700, 9'h4, 0);
    drive(0, 0, 0, 0, 1, 0, 3'b111, 16'h0800, 9'h4, 0);
    #3 rst_n = 1'b0;
    mz = 0; mv = 0; mn = 0; msh = 0;
    e_res = 0; e_tk = 0; e_fl = 0; e_tgt = 0;
    #1;
    chk_all();
    @(posedge clk);
    #1;
    chk_all();
    #2 rst_n = 1'b1;
    idle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 4) == 0,
           1'($urandom), 3'($urandom), 3'($urandom),
           $urandom_range(0, 2) != 0, 1'($urandom),
           3'($urandom), 16'($urandom), 9'($urandom),
           16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
